// File: rtl/note_seq_pkg.sv
// note_seq_pkg: shared types and constants for the note sequencer.
//   state_e     : playback FSM states
//   entry field : bit positions of a 5-bit table entry
//                 [4]=END marker, [3]=Tom (sharp), [2:0]=note {notas3,notas2,notas1}
package note_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        PAUSE = 2'd2
    } state_e;

    localparam int END_BIT  = 4;
    localparam int TOM_BIT  = 3;
    localparam int NOTE_LSB = 0;
    localparam int NOTE_W   = 3;
    localparam int ENTRY_W  = 5;

    // Display-facing part of an entry: {Tom, note[2:0]}
    function automatic logic [NOTE_W:0] entry_to_out(input logic [ENTRY_W-1:0] e);
        return {e[TOM_BIT], e[NOTE_LSB +: NOTE_W]};
    endfunction

endpackage

// File: rtl/note_sequencer_tempo_tick.sv
// tempo_tick: step-period counter for the note sequencer.
//   clk, rst  : clock, synchronous active-high reset
//   clr       : force the count to 0 (wins over en)
//   en        : advance the count by one; wraps after TICKS_PER_STEP-1
//   last_tick : high while count == TICKS_PER_STEP-1
module tempo_tick #(
    parameter int TICKS_PER_STEP = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic last_tick
);
    localparam int CNT_W = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;

    logic [CNT_W-1:0] count_q, count_d;

    assign last_tick = (count_q == CNT_W'(TICKS_PER_STEP - 1));

    always_comb begin
        count_d = count_q;
        if (clr)
            count_d = '0;
        else if (en)
            count_d = last_tick ? '0 : count_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

endmodule

// File: rtl/note_sequencer.sv
// note_sequencer: melody player feeding the note-to-7-segment decoder.
//   Holds a DEPTH-entry writable note table and plays it at TICKS_PER_STEP
//   clocks per note.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   wr_en, wr_addr, wr_data  : table write port (any state)
//   start, stop, pause       : playback control (priority rst > stop > start > pause)
//   Tom, notas1..3           : registered note outputs to the decoder
//   step                     : index of the entry being played
//   playing                  : high in PLAY or PAUSE
//   done                     : one-cycle pulse on natural end of melody
// Build option: define NOTE_SEQ_LOOP_EN to restart from entry 0 at the end of
//   the melody instead of returning to IDLE.
module note_sequencer
    import note_seq_pkg::*;
#(
    parameter int DEPTH          = 8,
    parameter int ADDR_W         = $clog2(DEPTH),
    parameter int TICKS_PER_STEP = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [4:0]        wr_data,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    output logic              Tom,
    output logic              notas1,
    output logic              notas2,
    output logic              notas3,
    output logic [ADDR_W-1:0] step,
    output logic              playing,
    output logic              done
);
    logic [DEPTH-1:0][ENTRY_W-1:0] table_q;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] step_q, step_d;
    logic [NOTE_W:0]   out_q, out_d;
    logic              done_q, done_d;

    logic              tick_clr, tick_en, last_tick;
    logic [ADDR_W-1:0] next_idx;
    logic [ENTRY_W-1:0] next_entry, first_entry;
    logic              end_of_mel, loop_ok, start_ok;

    // Table: no reset, writes land at the next edge and may target the
    // entry currently playing; outputs only pick it up on the next fetch.
    always_ff @(posedge clk) begin
        if (wr_en) table_q[wr_addr] <= wr_data;
    end

    tempo_tick #(.TICKS_PER_STEP(TICKS_PER_STEP)) u_tick (
        .clk       (clk),
        .rst       (rst),
        .clr       (tick_clr),
        .en        (tick_en),
        .last_tick (last_tick)
    );

    assign next_idx    = step_q + ADDR_W'(1);
    assign next_entry  = table_q[next_idx];
    assign first_entry = table_q[0];
    // Running off the last slot ends the melody even without an END marker.
    assign end_of_mel  = next_entry[END_BIT] || (step_q == ADDR_W'(DEPTH - 1));
    assign start_ok    = start && !stop;

`ifdef NOTE_SEQ_LOOP_EN
    // Looping to an empty melody would spin forever; fall back to a normal end.
    assign loop_ok = !first_entry[END_BIT];
`else
    assign loop_ok = 1'b0;
`endif

    // State register and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            step_q  <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            out_q   <= out_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start_ok && !first_entry[END_BIT]) state_d = PLAY;
            end
            PLAY: begin
                if (stop)                                     state_d = IDLE;
                else if (pause)                               state_d = PAUSE;
                else if (last_tick && end_of_mel && !loop_ok) state_d = IDLE;
            end
            PAUSE: begin
                if (stop)        state_d = IDLE;
                else if (!pause) state_d = PLAY;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath logic
    always_comb begin
        step_d   = step_q;
        out_d    = out_q;
        done_d   = 1'b0;
        tick_clr = 1'b0;
        tick_en  = 1'b0;
        unique case (state_q)
            IDLE: begin
                tick_clr = 1'b1;
                if (start_ok) begin
                    if (first_entry[END_BIT]) begin
                        done_d = 1'b1;
                    end else begin
                        step_d = '0;
                        out_d  = entry_to_out(first_entry);
                    end
                end
            end
            PLAY: begin
                if (stop) begin
                    step_d   = '0;
                    out_d    = '0;
                    tick_clr = 1'b1;
                end else if (pause) begin
                    // Freeze the tick; the note keeps sounding.
                    tick_en = 1'b0;
                end else if (last_tick) begin
                    tick_clr = 1'b1;
                    if (!end_of_mel) begin
                        step_d = next_idx;
                        out_d  = entry_to_out(next_entry);
                    end else if (loop_ok) begin
                        step_d = '0;
                        out_d  = entry_to_out(first_entry);
                        done_d = 1'b1;
                    end else begin
                        step_d = '0;
                        out_d  = '0;
                        done_d = 1'b1;
                    end
                end else begin
                    tick_en = 1'b1;
                end
            end
            PAUSE: begin
                if (stop) begin
                    step_d   = '0;
                    out_d    = '0;
                    tick_clr = 1'b1;
                end
            end
            default: begin
                step_d   = '0;
                out_d    = '0;
                tick_clr = 1'b1;
            end
        endcase
    end

    assign Tom     = out_q[NOTE_W];
    assign notas3  = out_q[2];
    assign notas2  = out_q[1];
    assign notas1  = out_q[0];
    assign step    = step_q;
    assign playing = (state_q != IDLE);
    assign done    = done_q;

endmodule

// File: tb/tb_note_sequencer.sv
module tb_note_sequencer;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int TPS   = 4;

    logic          clk = 1'b0;
    logic          rst, wr_en, start, stop, pause;
    logic [AW-1:0] wr_addr;
    logic [4:0]    wr_data;
    logic          Tom, notas1, notas2, notas3, playing, done;
    logic [AW-1:0] step;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    note_sequencer #(.DEPTH(DEPTH), .ADDR_W(AW), .TICKS_PER_STEP(TPS)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .stop(stop), .pause(pause),
        .Tom(Tom), .notas1(notas1), .notas2(notas2), .notas3(notas3),
        .step(step), .playing(playing), .done(done)
    );

    // ---------------- behavioural reference model ----------------
    // Tracks "is a melody running", "is it held", which entry is sounding and
    // how many un-paused cycles that entry has already been heard.
    logic [4:0]    m_tab [DEPTH];
    logic          m_act, m_held_on;
    logic [AW-1:0] m_step;
    logic [3:0]    m_out;
    logic          m_done;
    int            m_heard;
    int            nidx;

    always @(posedge clk) begin
        if (rst) begin
            m_act = 0; m_held_on = 0; m_step = 0; m_out = 0; m_done = 0; m_heard = 0;
        end else begin
            m_done = 0;
            if (!m_act) begin
                if (start && !stop) begin
                    if (m_tab[0][4]) m_done = 1;
                    else begin
                        m_act = 1; m_held_on = 0; m_step = 0; m_heard = 0;
                        m_out = m_tab[0][3:0];
                    end
                end
            end else if (stop) begin
                m_act = 0; m_held_on = 0; m_step = 0; m_out = 0; m_heard = 0;
            end else if (m_held_on) begin
                if (!pause) m_held_on = 0;
            end else if (pause) begin
                m_held_on = 1;
            end else if (m_heard + 1 < TPS) begin
                m_heard = m_heard + 1;
            end else begin
                nidx = (int'(m_step) + 1) % DEPTH;
                m_heard = 0;
                if (nidx != 0 && !m_tab[nidx][4]) begin
                    m_step = AW'(nidx);
                    m_out  = m_tab[nidx][3:0];
                end else begin
                    m_done = 1;
                    m_step = 0;
`ifdef NOTE_SEQ_LOOP_EN
                    if (!m_tab[0][4]) m_out = m_tab[0][3:0];
                    else begin m_out = 0; m_act = 0; end
`else
                    m_out = 0; m_act = 0;
`endif
                end
            end
        end
        if (wr_en) m_tab[wr_addr] = wr_data;
    end

    wire [8:0] obs   = {Tom, notas3, notas2, notas1, step, playing, done};
    wire [8:0] model = {m_out, m_step, m_act, m_done};

    task automatic drive(input logic r, input logic s, input logic sp, input logic p,
                         input logic we, input logic [AW-1:0] wa, input logic [4:0] wd);
        rst = r; start = s; stop = sp; pause = p; wr_en = we; wr_addr = wa; wr_data = wd;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        drive(1, 1, 0, 0, 0, 0, 0);
        @(negedge clk); @(negedge clk);
        checks++;
        if (obs !== 9'd0) begin errors++; $display("FAIL reset got %b want %b", obs, 9'd0); end
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (obs !== model) begin errors++; $display("FAIL reset_model got %b want %b", obs, model); end
    endtask

    task automatic test_basic;
        logic [4:0] d [3];
        d[0] = 5'b01010; d[1] = 5'b00011; d[2] = 5'b10000;
        for (int i = 0; i < 3; i++) begin drive(0, 0, 0, 0, 1, AW'(i), d[i]); @(negedge clk); end
        drive(0, 1, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            drive(0, 0, 0, 0, 0, 0, 0);
            checks++;
            if (obs !== model) begin errors++; $display("FAIL basic_model k=%0d got %b want %b", k, obs, model); end
            checks++;
            if (k <= 4 && {Tom, notas3, notas2, notas1, playing, done} !== 6'b1010_10) begin
                errors++; $display("FAIL basic_n0 k=%0d got %b want 101010", k, {Tom, notas3, notas2, notas1, playing, done});
            end else if (k >= 5 && k <= 8 && {Tom, notas3, notas2, notas1, playing, done} !== 6'b0011_10) begin
                errors++; $display("FAIL basic_n1 k=%0d got %b want 001110", k, {Tom, notas3, notas2, notas1, playing, done});
            end else if (k == 9 && {Tom, notas3, notas2, notas1, playing, done} !== 6'b0000_01) begin
                errors++; $display("FAIL basic_end k=%0d got %b want 000001", k, {Tom, notas3, notas2, notas1, playing, done});
            end else if (k >= 10 && {Tom, notas3, notas2, notas1, playing, done} !== 6'b0000_00) begin
                errors++; $display("FAIL basic_idle k=%0d got %b want 000000", k, {Tom, notas3, notas2, notas1, playing, done});
            end
        end
    endtask

    task automatic test_end_first;
        drive(0, 0, 0, 0, 1, 0, 5'b10000); @(negedge clk);
        drive(0, 1, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            drive(0, 0, 0, 0, 0, 0, 0);
            checks++;
            if ({playing, done} !== ((k == 1) ? 2'b01 : 2'b00) || obs !== model) begin
                errors++; $display("FAIL end_first k=%0d got %b want %b", k, obs, model);
            end
        end
    endtask

    task automatic test_pause;
        drive(0, 0, 0, 0, 1, 0, 5'b01010); @(negedge clk);
        drive(0, 1, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            drive(0, 0, 0, (k >= 3 && k <= 8), 0, 0, 0);
            checks++;
            if (obs !== model) begin errors++; $display("FAIL pause_model k=%0d got %b want %b", k, obs, model); end
            if (k <= 11) begin
                checks++;
                if ({Tom, notas3, notas2, notas1, playing} !== 5'b1010_1) begin
                    errors++; $display("FAIL pause_hold k=%0d got %b want 10101", k, {Tom, notas3, notas2, notas1, playing});
                end
            end else if (k == 12) begin
                checks++;
                if ({Tom, notas3, notas2, notas1, step} !== 7'b0011_001) begin
                    errors++; $display("FAIL pause_resume got %b want 0011001", {Tom, notas3, notas2, notas1, step});
                end
            end
        end
    endtask

    task automatic test_stop;
        drive(0, 1, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            drive(0, 0, (k == 6), 0, 0, 0, 0);
            checks++;
            if (obs !== model) begin errors++; $display("FAIL stop_model k=%0d got %b want %b", k, obs, model); end
            if (k >= 7) begin
                checks++;
                if (obs !== 9'd0) begin errors++; $display("FAIL stop_idle k=%0d got %b want 0", k, obs); end
            end
        end
    endtask

    task automatic test_loop;
        logic [4:0] t0;
        int dones;
        dones = 0;
        for (int i = 0; i < DEPTH; i++) begin
            drive(0, 0, 0, 0, 1, AW'(i), {1'b0, 4'($urandom)});
            if (i == 0) t0 = wr_data;
            @(negedge clk);
        end
        drive(0, 1, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            drive(0, 0, 0, 0, 0, 0, 0);
            if (done === 1'b1) dones++;
            checks++;
            if (obs !== model) begin errors++; $display("FAIL loop_model k=%0d got %b want %b", k, obs, model); end
            if (k == 33) begin
                checks++;
`ifdef NOTE_SEQ_LOOP_EN
                if ({Tom, notas3, notas2, notas1, step, playing, done} !== {t0[3:0], 3'd0, 2'b11}) begin
                    errors++; $display("FAIL loop_wrap got %b want %b", obs, {t0[3:0], 3'd0, 2'b11});
                end
`else
                if (obs !== 9'b0000_000_01) begin errors++; $display("FAIL loop_end got %b want 000000001", obs); end
`endif
            end
        end
        checks++;
        if (dones != 1) begin errors++; $display("FAIL loop_dones got %0d want 1", dones); end
        drive(0, 0, 1, 0, 0, 0, 0); @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset_mid;
        drive(0, 1, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            drive((k == 3), (k == 3), 0, 0, 0, 0, 0);
            checks++;
            if (obs !== model) begin errors++; $display("FAIL rstmid_model k=%0d got %b want %b", k, obs, model); end
            if (k >= 4) begin
                checks++;
                if (obs !== 9'd0) begin errors++; $display("FAIL rstmid k=%0d got %b want 0", k, obs); end
            end
        end
    endtask

    task automatic test_random;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            checks++;
            if (obs !== model) begin errors++; $display("FAIL random k=%0d got %b want %b", k, obs, model); end
            drive($urandom_range(0, 79) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 24) == 0,
                  $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0, AW'($urandom),
                  {($urandom_range(0, 5) == 0), 4'($urandom)});
        end
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0);
        test_reset;
        test_basic;
        test_end_first;
        test_pause;
        test_stop;
        test_loop;
        test_reset_mid;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
